conv1_chan_sched: RTL and testbench
===================================

// Module: conv1_chan_sched
// PURPOSE
//  Output-channel scheduler for the conv1 layer. On start, walks output channels 0..N-1.
//  Per channel: fetch the channel's bias from the conv1 bias ROM, launch the conv datapath,
//  gate the pixel stream for exactly one feature map, wait for datapath done, advance.
//  Sits between the top-level layer sequencer and the conv1 MAC/bias-add datapath.
// PARAMETERS
//  BIAS_W   8   bias word width (ROM data width)
//  CH_W     3   channel index / ROM address width
//  MAX_CH   6   max output channels; ROM depth
//  PIX_W    10  pixel-count width (pixels per output feature map)
//  ROM_LAT  1   ROM read latency in clk cycles (rom_en -> rom_dout valid), 1..3
// PORTS
//  clk        in   1        clock
//  rst_n      in   1        reset, asynchronous, active-low
//  start      in   1        1-cycle pulse: begin layer; ignored while busy
//  cfg_oc_num in   CH_W     output channels this layer; sampled on accepted start
//  cfg_pix_num in  PIX_W    pixels per feature map; sampled on accepted start
//  busy       out  1        high from cycle after accepted start until done
//  done       out  1        1-cycle pulse: all channels finished
//  rom_en     out  1        bias ROM read enable
//  rom_addr   out  CH_W     bias ROM address = current channel index
//  rom_dout   in   BIAS_W   bias ROM read data
//  bias_vld   out  1        bias holds current channel's bias
//  bias       out  BIAS_W   registered bias for current channel
//  chan_idx   out  CH_W     current output channel
//  dp_start   out  1        1-cycle pulse: datapath begin channel
//  pix_vld    in   1        upstream pixel valid
//  pix_rdy    out  1        pixel accept; transfer = pix_vld & pix_rdy
//  dp_done    in   1        1-cycle pulse: datapath drained current channel
// BEHAVIOUR
//  Reset: state IDLE; busy, done, rom_en, bias_vld, dp_start, pix_rdy = 0; rom_addr,
//   chan_idx, bias, counters = 0. Reset mid-layer aborts immediately, no done pulse.
//  FSM: IDLE -> FETCH -> WAIT_B -> RUN -> DRAIN -> (FETCH | FIN) -> IDLE.
//  IDLE: start=1 latches cfg; cfg_oc_num>MAX_CH clamps to MAX_CH; cfg_oc_num=0 -> FIN.
//  FETCH (1 cycle): rom_en=1, rom_addr=chan_idx; bias_vld=0.
//  WAIT_B: ROM_LAT cycles counted; final cycle registers rom_dout into bias; next cycle
//   bias_vld=1, dp_start=1 (single pulse), enter RUN. Bias stable for whole channel.
//  RUN: pix_rdy=1; pixel counter increments per transfer; on transfer cfg_pix_num
//   pix_rdy drops next cycle, enter DRAIN. cfg_pix_num=0: skip RUN, dp_start then DRAIN.
//  DRAIN: pix_rdy=0; wait dp_done. Then if chan_idx==oc_num-1 -> FIN, else chan_idx+1,
//   pixel counter cleared -> FETCH. dp_done outside DRAIN ignored (no state change).
//  FIN (1 cycle): done=1, busy=0 next cycle, bias_vld=0 -> IDLE.
//  Latency: start@T0 -> rom_en@T1 -> dp_start@T2+ROM_LAT; channel turnaround dp_done@Tn
//   -> rom_en@Tn+1.
//  Counters never wrap: chan_idx < MAX_CH, pixel count saturates at cfg_pix_num.
//  start during busy: dropped, cfg untouched. start coincident with FIN: dropped.
// STRUCTURE
//  Shared package conv1_pkg: FSM state enum, MAX_CH, CH_W, BIAS_W, PIX_W constants.
//  One sub-module natural: conv1_pix_cnt (pixel transfer counter, terminal-count flag).
//  Bias ROM instantiated outside; this block drives only its enable/address.
// TESTING
//  oc=6, pix=4, pix_vld=1, dp_done 3 cycles after last pix -> rom_addr 0..5 in order,
//   6 dp_start, 24 transfers, bias matches ROM[k] per channel, one done pulse.
//  oc=2, pix=5, pix_vld toggling 1/0 -> exactly 5 transfers per channel, pix_rdy low in DRAIN.
//  oc=7 (>MAX_CH) -> clamped: 6 channels processed, rom_addr never exceeds 5.
//  oc=0 -> no rom_en, no dp_start; done 2 cycles after start; busy pulse 1 cycle.
//  start re-pulsed mid-RUN with different cfg -> ignored; original sequence completes.
//  rst_n low during ch3 RUN -> all outputs 0 same cycle; new start restarts at ch0.

Source files
------------

// File: rtl/conv1_pkg.sv
// conv1_pkg: shared widths, channel limit and scheduler FSM states for conv1
package conv1_pkg;
  localparam int BIAS_W = 8;
  localparam int CH_W = 3;
  localparam int MAX_CH = 6;
  localparam int PIX_W = 10;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_B, RUN, DRAIN, FIN} state_t;
endpackage

// File: rtl/conv1_pix_cnt.sv
// conv1_pix_cnt: per-channel pixel transfer counter, saturating at lim, tc on the final transfer
module conv1_pix_cnt
  import conv1_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [PIX_W-1:0] lim,
  output logic             tc
);
  logic [PIX_W-1:0] cnt;
  assign tc = inc && (cnt + 1'b1 == lim);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt != lim) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/conv1_chan_sched.sv
// conv1_chan_sched: walks conv1 output channels, fetching each bias and gating one feature map per channel
module conv1_chan_sched
  import conv1_pkg::*;
#(
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CH_W-1:0]   cfg_oc_num,
  input  logic [PIX_W-1:0]  cfg_pix_num,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [CH_W-1:0]   rom_addr,
  input  logic [BIAS_W-1:0] rom_dout,
  output logic              bias_vld,
  output logic [BIAS_W-1:0] bias,
  output logic [CH_W-1:0]   chan_idx,
  output logic              dp_start,
  input  logic              pix_vld,
  output logic              pix_rdy,
  input  logic              dp_done
);
  state_t state, nxt;
  logic [CH_W-1:0] oc_num, oc_clamp;
  logic [PIX_W-1:0] pix_num;
  logic [1:0] lat_cnt;
  logic accept, lat_last, last_ch, ch_adv, pix_tc;
  assign accept = state == IDLE && start;
  assign lat_last = lat_cnt == 2'(ROM_LAT - 1);
  assign last_ch = chan_idx == oc_num - 1'b1;
  assign ch_adv = state == DRAIN && dp_done;
  assign oc_clamp = cfg_oc_num > CH_W'(MAX_CH) ? CH_W'(MAX_CH) : cfg_oc_num;
  assign busy = state != IDLE;
  assign rom_en = state == FETCH;
  assign rom_addr = chan_idx;
  assign bias_vld = state == RUN || state == DRAIN;
  assign pix_rdy = state == RUN;
  conv1_pix_cnt u_pix_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept || ch_adv),
    .inc  (pix_vld && pix_rdy),
    .lim  (pix_num),
    .tc   (pix_tc)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = oc_clamp == '0 ? FIN : FETCH;
      FETCH:   nxt = WAIT_B;
      WAIT_B:  if (lat_last) nxt = pix_num == '0 ? DRAIN : RUN;
      RUN:     if (pix_tc) nxt = DRAIN;
      DRAIN:   if (dp_done) nxt = last_ch ? FIN : FETCH;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // dp_start and done are registered so each is a clean single-cycle pulse after its trigger state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      oc_num   <= '0;
      pix_num  <= '0;
      chan_idx <= '0;
      lat_cnt  <= '0;
      bias     <= '0;
      dp_start <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= nxt;
      done     <= state == FIN;
      dp_start <= state == WAIT_B && lat_last;
      lat_cnt  <= state == WAIT_B ? lat_cnt + 1'b1 : 2'd0;
      if (state == WAIT_B && lat_last) bias <= rom_dout;
      if (accept) begin
        oc_num   <= oc_clamp;
        pix_num  <= cfg_pix_num;
        chan_idx <= '0;
      end else if (ch_adv && !last_ch) chan_idx <= chan_idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_conv1_chan_sched.sv
// tb_conv1_chan_sched: randomized layers against a sequential reference model of the channel schedule
module tb_conv1_chan_sched;
  import conv1_pkg::*;
  localparam int LAT = 2;
  logic clk = 0, rst_n = 1, start = 0, pix_vld = 0, dp_done = 0;
  logic [CH_W-1:0] cfg_oc_num = '0;
  logic [PIX_W-1:0] cfg_pix_num = '0;
  logic busy, done, rom_en, bias_vld, dp_start, pix_rdy;
  logic [CH_W-1:0] rom_addr, chan_idx;
  logic [BIAS_W-1:0] rom_dout, bias;
  logic [BIAS_W-1:0] rom [0:7];
  logic [BIAS_W-1:0] pipe [0:LAT-1];
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;

  conv1_chan_sched #(.ROM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_oc_num(cfg_oc_num), .cfg_pix_num(cfg_pix_num),
    .busy(busy), .done(done), .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .bias_vld(bias_vld), .bias(bias), .chan_idx(chan_idx), .dp_start(dp_start),
    .pix_vld(pix_vld), .pix_rdy(pix_rdy), .dp_done(dp_done)
  );

  // bias ROM with LAT-cycle read latency; junk on the bus whenever no read is in flight
  assign rom_dout = pipe[LAT-1];
  always @(posedge clk) begin
    pipe[0] <= rom_en ? rom[rom_addr] : BIAS_W'($urandom);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: walks the layer as a plain program, one call to cyc per clock
  logic e_busy = 0, e_done = 0, e_en = 0, e_bv = 0, e_ds = 0, e_pr = 0;
  int m_ch = 0;
  bit ab = 0;
  always @(negedge rst_n) ab = 1;

  task automatic setx(input logic b, re, bv, ds, pr, dn);
    e_busy = b; e_en = re; e_bv = bv; e_ds = ds; e_pr = pr; e_done = dn;
  endtask

  task automatic cyc(input logic re, bv, ds, pr);
    setx(1, re, bv, ds, pr, 0);
    @(posedge clk);
  endtask

  task automatic layer(input int oc, input int pix);
    int n, got;
    bit first;
    n = oc > MAX_CH ? MAX_CH : oc;
    for (int ch = 0; ch < n; ch++) begin
      m_ch = ch;
      cyc(1, 0, 0, 0);
      if (ab) return;
      for (int i = 0; i < LAT; i++) begin
        cyc(0, 0, 0, 0);
        if (ab) return;
      end
      first = 1;
      got = 0;
      while (got < pix) begin
        cyc(0, 1, first, 1);
        if (ab) return;
        first = 0;
        if (pix_vld) got++;
      end
      do begin
        cyc(0, 1, first, 0);
        if (ab) return;
        first = 0;
      end while (!dp_done);
    end
    cyc(0, 0, 0, 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (ab || !rst_n) begin
        ab = 0; m_ch = 0; setx(0, 0, 0, 0, 0, 0);
      end else if (start) begin
        m_ch = 0;
        layer(int'(cfg_oc_num), int'(cfg_pix_num));
        if (ab || !rst_n) begin
          ab = 0; m_ch = 0; setx(0, 0, 0, 0, 0, 0);
        end else setx(0, 0, 0, 0, 0, 1);
      end else setx(0, 0, 0, 0, 0, 0);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_rom_en", rom_en, 0);
      chk("rst_bias_vld", bias_vld, 0); chk("rst_dp_start", dp_start, 0); chk("rst_pix_rdy", pix_rdy, 0);
      chk("rst_chan_idx", chan_idx, 0); chk("rst_rom_addr", rom_addr, 0); chk("rst_bias", bias, 0);
    end else begin
      chk("busy", busy, e_busy); chk("done", done, e_done); chk("rom_en", rom_en, e_en);
      chk("bias_vld", bias_vld, e_bv); chk("dp_start", dp_start, e_ds); chk("pix_rdy", pix_rdy, e_pr);
      chk("chan_idx", chan_idx, m_ch); chk("rom_addr", rom_addr, m_ch);
      if (e_bv) chk("bias", bias, rom[m_ch]);
    end
  end

  // event counters for the literal per-scenario expectations
  int cyc_n = 0, st_c = 0, dn_c = 0, n_en = 0, n_ds = 0, n_xf = 0, n_dn = 0, n_bz = 0, max_a = 0;
  int alog[$];
  always @(negedge clk) begin
    cyc_n++;
    if (start) st_c = cyc_n;
    if (rst_n) begin
      if (rom_en) begin
        n_en++;
        alog.push_back(int'(rom_addr));
        if (int'(rom_addr) > max_a) max_a = int'(rom_addr);
      end
      if (dp_start) n_ds++;
      if (pix_vld && pix_rdy) n_xf++;
      if (done) begin n_dn++; dn_c = cyc_n; end
      if (busy) n_bz++;
    end
  end

  // upstream pixels and datapath done responder
  int mode = 0, dly = 3, lay_pix = 0, armed = 0, got_px = 0, cd = 0;
  logic spur = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        armed = 0; cd = 0;
      end else begin
        if (dp_start) begin armed = 1; got_px = 0; end
        if (pix_vld && pix_rdy) got_px++;
        if (armed != 0 && got_px >= lay_pix) begin armed = 0; cd = dly; end
      end
      @(posedge clk);
      #1;
      dp_done = (cd == 1) || spur;
      if (cd > 0) cd--;
      pix_vld = mode == 0 ? 1'b1 : mode == 1 ? ~pix_vld : 1'($urandom % 2);
    end
  end

  task automatic clr_cnt();
    n_en = 0; n_ds = 0; n_xf = 0; n_dn = 0; n_bz = 0; max_a = 0; alog.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
  endtask

  task automatic pulse_start(input int oc, input int pix);
    @(posedge clk);
    #1;
    start = 1; cfg_oc_num = CH_W'(oc); cfg_pix_num = PIX_W'(pix);
    @(posedge clk);
    #1;
    start = 0; cfg_oc_num = CH_W'($urandom); cfg_pix_num = PIX_W'($urandom);
  endtask

  task automatic wait_done();
    int k = 0;
    while (n_dn == 0 && k < 3000) begin @(posedge clk); k++; end
    chk("done_timeout", int'(k < 3000), 1);
    if (k >= 3000) do_reset();
    repeat (3) @(posedge clk);
  endtask

  task automatic run(input int oc, input int pix, input int m, input int d);
    mode = m; dly = d; lay_pix = pix;
    clr_cnt();
    pulse_start(oc, pix);
    wait_done();
    chk("done_pulses", n_dn, 1);
  endtask

  task automatic wait_run_ch(input int ch);
    int k = 0;
    while (!(pix_rdy && int'(chan_idx) == ch) && k < 2000) begin @(negedge clk); k++; end
    chk("wait_run", int'(k < 2000), 1);
  endtask

  initial begin
    int oc, pix, n;
    for (int i = 0; i < 8; i++) rom[i] = BIAS_W'($urandom);
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    repeat (2) @(posedge clk);
    // dp_done while idle must be ignored
    @(negedge clk) spur = 1;
    @(negedge clk) spur = 0;
    repeat (3) @(posedge clk);
    chk("idle_busy_after_spurious_done", n_bz, 0);

    run(6, 4, 0, 3);
    chk("t1_rom_en", n_en, 6);
    for (int i = 0; i < 6; i++) chk("t1_addr_order", alog.size() > i ? alog[i] : -1, i);
    chk("t1_dp_start", n_ds, 6);
    chk("t1_xfers", n_xf, 24);

    run(2, 5, 1, 2);
    chk("t2_xfers", n_xf, 10);
    chk("t2_dp_start", n_ds, 2);

    run(7, 3, 2, 1);
    chk("t3_rom_en", n_en, 6);
    chk("t3_max_addr", max_a, 5);

    run(0, 4, 0, 1);
    chk("t4_done_latency", dn_c - st_c, 2);
    chk("t4_busy_cycles", n_bz, 1);
    chk("t4_rom_en", n_en, 0);
    chk("t4_dp_start", n_ds, 0);

    // second start mid-RUN with a different cfg must be dropped
    mode = 2; dly = 2; lay_pix = 6;
    clr_cnt();
    pulse_start(3, 6);
    wait_run_ch(0);
    pulse_start(1, 2);
    wait_done();
    chk("t5_rom_en", n_en, 3);
    chk("t5_xfers", n_xf, 18);
    chk("t5_done", n_dn, 1);

    // reset during channel 3 RUN aborts at once
    mode = 0; dly = 3; lay_pix = 8;
    clr_cnt();
    pulse_start(6, 8);
    wait_run_ch(3);
    #2 rst_n = 0;
    #1;
    chk("t6_busy", busy, 0); chk("t6_pix_rdy", pix_rdy, 0); chk("t6_bias_vld", bias_vld, 0);
    chk("t6_chan_idx", chan_idx, 0); chk("t6_done", done, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    chk("t6_no_done", n_dn, 0);
    run(2, 2, 0, 1);
    chk("t6_restart_addr", alog.size() > 0 ? alog[0] : -1, 0);
    chk("t6_restart_rom_en", n_en, 2);

    for (int r = 0; r < 8; r++) begin
      oc = $urandom_range(0, 7);
      pix = $urandom_range(0, 6);
      n = oc > MAX_CH ? MAX_CH : oc;
      run(oc, pix, $urandom_range(0, 2), $urandom_range(1, 4));
      chk("rnd_rom_en", n_en, n);
      chk("rnd_xfers", n_xf, n * pix);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
